key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 15 +
 rtl/key_debounce_if.sv | 28 ++
 rtl/key_debounce_chan.sv | 99 +++++++++
 rtl/key_debounce.sv | 30 +++
 tb/tb_key_debounce.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the pushbutton debouncer.
// Holds the per-channel state enum and the default qualification length.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    UP,
    WAIT_DOWN,
    DOWN,
    WAIT_UP
  } chan_state_e;

  // 20 ms at a 50 MHz system clock
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/key_debounce_if.sv
// Pushbutton bundle: raw active-low keys in, debounced level and edge pulses out.
interface key_debounce_if #(
  parameter int unsigned N_KEYS = 4
);

  logic [N_KEYS-1:0] KEY;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic              any_press;

  modport master (
    output KEY,
    input  key_level,
    input  key_press,
    input  key_release,
    input  any_press
  );

  modport slave (
    input  KEY,
    output key_level,
    output key_press,
    output key_release,
    output any_press
  );

endinterface

// File: rtl/key_debounce_chan.sv
// One debounced pushbutton: two-flop synchronizer, qualification FSM with a
// saturating-by-construction counter, and registered level/press/release outputs.
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync_meta_q;
  logic            s_q;
  chan_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  // Synchronizer idles at 1 (released) so reset never looks like a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_meta_q <= 1'b1;
      s_q         <= 1'b1;
      state_q     <= UP;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      sync_meta_q <= key_ni;
      s_q         <= sync_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      UP: begin
        if (!s_q) begin
          state_d = WAIT_DOWN;
          cnt_d   = '0;
        end
      end
      WAIT_DOWN: begin
        if (s_q) begin
          state_d = UP;
        end else if (cnt_q == CntLast) begin
          state_d = DOWN;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (s_q) begin
          state_d = WAIT_UP;
          cnt_d   = '0;
        end
      end
      WAIT_UP: begin
        if (!s_q) begin
          state_d = DOWN;
        end else if (cnt_q == CntLast) begin
          state_d   = UP;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = UP;
        cnt_d   = '0;
      end
    endcase
    // Level is registered from the next state so it tracks DOWN/WAIT_UP exactly.
    level_d = (state_d == DOWN) || (state_d == WAIT_UP);
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// Debouncer for a bank of pushbuttons: one independent channel per key plus
// an OR of the press pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input logic            CLOCK_50,
  input logic            Resetn,
  key_debounce_if.slave  keys
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i    (CLOCK_50),
      .rst_ni   (Resetn),
      .key_ni   (keys.KEY[g]),
      .level_o  (keys.key_level[g]),
      .press_o  (keys.key_press[g]),
      .release_o(keys.key_release[g])
    );
  end

  // Press pulses are already registered, so the OR stays in the same cycle.
  assign keys.any_press = |keys.key_press;

endmodule

// File: tb/tb_key_debounce.sv
// Randomized and directed bench for key_debounce, checked against a model that
// flips each key's level after DEBOUNCE_CYCLES+1 consecutive disagreeing samples.
module tb_key_debounce;

  localparam int NK = 4;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  key_debounce_if #(.N_KEYS(NK)) bus ();

  key_debounce #(
    .N_KEYS(NK),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLOCK_50(clk),
    .Resetn  (resetn),
    .keys    (bus)
  );

  int compareCount = 0;
  int mismatchCount = 0;

  logic [NK-1:0] mLevel, mPress, mRelease, hist1, hist2;
  int runLen[NK];

  int pressSeen[NK];
  int releaseSeen[NK];
  int levelCycles[NK];
  int firstPressEdge[NK];
  int anyCycles;
  int edgeCount;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mLevel   = '0;
    mPress   = '0;
    mRelease = '0;
    hist1    = '1;
    hist2    = '1;
    for (int i = 0; i < NK; i++) runLen[i] = 0;
  endtask

  // Level flips once the synchronized key has disagreed with it for DB+1 edges in a row.
  task automatic modelEdge(input logic [NK-1:0] keyVal);
    logic [NK-1:0] sSeen;
    sSeen    = hist2;
    hist2    = hist1;
    hist1    = keyVal;
    mPress   = '0;
    mRelease = '0;
    for (int i = 0; i < NK; i++) begin
      if ((~sSeen[i]) != mLevel[i]) begin
        runLen[i]++;
        if (runLen[i] == DB + 1) begin
          mLevel[i] = ~mLevel[i];
          if (mLevel[i]) mPress[i] = 1'b1;
          else           mRelease[i] = 1'b1;
          runLen[i] = 0;
        end
      end else begin
        runLen[i] = 0;
      end
    end
  endtask

  task automatic clearStats();
    for (int i = 0; i < NK; i++) begin
      pressSeen[i]      = 0;
      releaseSeen[i]    = 0;
      levelCycles[i]    = 0;
      firstPressEdge[i] = -1;
    end
    anyCycles = 0;
    edgeCount = 0;
  endtask

  task automatic checkAllOutputs();
    checkOutput("level",   32'(bus.key_level),   32'(mLevel));
    checkOutput("press",   32'(bus.key_press),   32'(mPress));
    checkOutput("release", 32'(bus.key_release), 32'(mRelease));
    checkOutput("any",     32'(bus.any_press),   32'(|mPress));
  endtask

  task automatic applyStimulus(input logic [NK-1:0] keyVal);
    bus.KEY = keyVal;
    @(posedge clk);
    modelEdge(keyVal);
    #1;
    edgeCount++;
    checkAllOutputs();
    for (int i = 0; i < NK; i++) begin
      if (bus.key_press[i] === 1'b1) begin
        pressSeen[i]++;
        if (firstPressEdge[i] < 0) firstPressEdge[i] = edgeCount;
      end
      if (bus.key_release[i] === 1'b1) releaseSeen[i]++;
      if (bus.key_level[i] === 1'b1) levelCycles[i]++;
    end
    if (bus.any_press === 1'b1) anyCycles++;
  endtask

  task automatic holdKeys(input logic [NK-1:0] keyVal, input int n);
    for (int c = 0; c < n; c++) applyStimulus(keyVal);
  endtask

  // Asserted between edges; outputs must clear before any further edge arrives.
  task automatic doReset(input int n);
    resetn = 1'b0;
    #1;
    modelReset();
    checkAllOutputs();
    for (int c = 0; c < n; c++) @(posedge clk);
    #1;
    checkAllOutputs();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [NK-1:0] keys;
    int            bouncy;
    int            resetAt;

    $display("[TB] key_debounce bench, N_KEYS=%0d DEBOUNCE_CYCLES=%0d", NK, DB);
    bus.KEY = '1;
    clearStats();
    doReset(3);
    holdKeys(4'b1111, 8);

    // Single press on key 0 held long enough to qualify.
    clearStats();
    holdKeys(4'b1110, 12);
    checkOutput("k0_press_count", 32'(pressSeen[0]), 32'd1);
    checkOutput("k0_press_edge", 32'(firstPressEdge[0]), 32'(DB + 3));
    checkOutput("k0_others_quiet", 32'(pressSeen[1] + pressSeen[2] + pressSeen[3]), 32'd0);
    holdKeys(4'b1111, 12);

    // Bouncing key 1 never qualifies.
    clearStats();
    holdKeys(4'b1101, 2);
    holdKeys(4'b1111, 1);
    holdKeys(4'b1101, 2);
    holdKeys(4'b1111, 10);
    checkOutput("k1_bounce_press", 32'(pressSeen[1]), 32'd0);
    checkOutput("k1_bounce_level", 32'(levelCycles[1]), 32'd0);

    // Key 2 held for 20 cycles gives a level exactly 20 cycles wide.
    clearStats();
    holdKeys(4'b1011, 20);
    holdKeys(4'b1111, 15);
    checkOutput("k2_press_count", 32'(pressSeen[2]), 32'd1);
    checkOutput("k2_release_count", 32'(releaseSeen[2]), 32'd1);
    checkOutput("k2_level_width", 32'(levelCycles[2]), 32'd20);

    // All keys pressed together.
    clearStats();
    holdKeys(4'b0000, 12);
    checkOutput("all_any_cycles", 32'(anyCycles), 32'd1);
    checkOutput("all_press_total", 32'(pressSeen[0] + pressSeen[1] + pressSeen[2] + pressSeen[3]), 32'd4);
    checkOutput("all_same_edge", 32'(firstPressEdge[0] == firstPressEdge[3]), 32'd1);
    holdKeys(4'b1111, 12);

    // Reset in the middle of qualifying key 0, key still held afterwards.
    clearStats();
    holdKeys(4'b1110, 5);
    doReset(2);
    clearStats();
    holdKeys(4'b1110, 10);
    checkOutput("rst_k0_press_edge", 32'(firstPressEdge[0]), 32'(DB + 3));
    checkOutput("rst_k0_press_count", 32'(pressSeen[0]), 32'd1);
    holdKeys(4'b1111, 12);

    // Long hold on key 1.
    clearStats();
    holdKeys(4'b1101, 1000);
    checkOutput("k1_long_press_count", 32'(pressSeen[1]), 32'd1);
    checkOutput("k1_long_level", 32'(levelCycles[1]), 32'(1000 - DB - 2));
    holdKeys(4'b1111, 12);

    // Random bouncing with occasional stable stretches and a mid-run reset.
    keys = '1;
    for (int round = 0; round < 4; round++) begin
      resetAt = $urandom_range(50, 250);
      for (int c = 0; c < 300; c++) begin
        if (c % 25 == 0) bouncy = $urandom_range(0, 1);
        for (int i = 0; i < NK; i++) begin
          if (bouncy != 0) begin
            if ($urandom_range(0, 2) == 0) keys[i] = ~keys[i];
          end else begin
            if ($urandom_range(0, 39) == 0) keys[i] = ~keys[i];
          end
        end
        applyStimulus(keys);
        if (c == resetAt) doReset($urandom_range(1, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
